// File: rtl/mem_bus_controller.sv
// ---------------------------------------------------------------------------
// mem_bus_controller
//
// Purpose:
//   Decodes CPU reads and writes into a ROM region, a RAM region and N_IO
//   memory-mapped IO channels. Reads are accepted with a ready/valid handshake
//   and complete strictly in order after a per-region latency. Writes are
//   always accepted and pass through a single register stage before reaching
//   RAM or IO. A RAM read that hits the address held in the write stage gets
//   the pending write data instead of the RAM output. Accesses that decode to
//   no region raise the sticky bus_error flag.
//
// Address map (addr[15:14]):
//   00, 01 : ROM  (rom_addr = addr[14:0])
//   10     : RAM  (14-bit word address)
//   11     : IO   (lowest-index channel with (addr & MASK) == BASE wins),
//            otherwise unmapped
//
// Ports:
//   clock, reset_n                  clock and synchronous active-low reset
//   rd_req, rd_addr, rd_ready       read request side
//   rd_valid, rd_data, rd_err       read completion side
//   wr_req, wr_addr, wr_data        write request side (never stalls)
//   rom_addr, rom_q                 ROM read port
//   ram_rdaddr, ram_q               RAM read port
//   ram_wraddr, ram_wdata, ram_wren RAM write port
//   io_raddr, io_ren, io_rdata      IO read port (offset, one-hot strobe, packed data)
//   io_waddr, io_wdata, io_wen      IO write port (offset, data, one-hot strobe)
//   bus_error                       sticky unmapped-access flag
// ---------------------------------------------------------------------------
module mem_bus_controller #(
  parameter int                 DATA_W  = 16,
  parameter int                 N_IO    = 2,
  parameter logic [N_IO*16-1:0] IO_BASE = {16'hC000, 16'hFFFF},
  parameter logic [N_IO*16-1:0] IO_MASK = {16'hC000, 16'hFFFF},
  parameter int                 ROM_LAT = 1,
  parameter int                 RAM_LAT = 1,
  parameter int                 IO_LAT  = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,

  input  logic                   rd_req,
  input  logic [15:0]            rd_addr,
  output logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_err,

  input  logic                   wr_req,
  input  logic [15:0]            wr_addr,
  input  logic [DATA_W-1:0]      wr_data,

  output logic [14:0]            rom_addr,
  input  logic [DATA_W-1:0]      rom_q,

  output logic [13:0]            ram_rdaddr,
  output logic [13:0]            ram_wraddr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_wren,
  input  logic [DATA_W-1:0]      ram_q,

  output logic [15:0]            io_raddr,
  output logic [N_IO-1:0]        io_ren,
  input  logic [N_IO*DATA_W-1:0] io_rdata,
  output logic [15:0]            io_waddr,
  output logic [DATA_W-1:0]      io_wdata,
  output logic [N_IO-1:0]        io_wen,

  output logic                   bus_error
);

  typedef enum logic [1:0] {
    REG_ROM      = 2'd0,
    REG_RAM      = 2'd1,
    REG_IO       = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_t;

  typedef struct packed {
    region_t    region;
    logic [2:0] chan;
  } decode_t;

  // One entry per in-flight read. The entry index is the number of cycles
  // until that read completes, so entry 0 is the read completing right now.
  typedef struct packed {
    logic              valid;
    region_t           region;
    logic [2:0]        chan;
    logic              fwd;
    logic [DATA_W-1:0] fdata;
  } tag_t;

  // Region decode. The channel loop runs from the highest index downwards so
  // that the lowest matching channel is the one left standing.
  function automatic decode_t decode_addr(input logic [15:0] addr);
    decode_t d;
    d.region = REG_ROM;
    d.chan   = 3'd0;
    case (addr[15:14])
      2'b00, 2'b01: d.region = REG_ROM;
      2'b10:        d.region = REG_RAM;
      default: begin
        d.region = REG_UNMAPPED;
        for (int i = N_IO - 1; i >= 0; i--) begin
          if ((addr & IO_MASK[i*16 +: 16]) == IO_BASE[i*16 +: 16]) begin
            d.region = REG_IO;
            d.chan   = 3'(i);
          end
        end
      end
    endcase
    return d;
  endfunction

  // Unmapped reads still need a slot in the pipeline to report rd_err.
  function automatic logic [2:0] latency_of(input region_t r);
    logic [2:0] l;
    case (r)
      REG_ROM: l = 3'(ROM_LAT);
      REG_RAM: l = 3'(RAM_LAT);
      REG_IO:  l = 3'(IO_LAT);
      default: l = 3'd1;
    endcase
    return l;
  endfunction

  function automatic logic [15:0] io_base_of(input logic [2:0] ch);
    logic [15:0] b;
    b = 16'h0000;
    for (int i = 0; i < N_IO; i++) begin
      if (ch == 3'(i)) b = IO_BASE[i*16 +: 16];
    end
    return b;
  endfunction

  function automatic logic [N_IO-1:0] onehot_of(input logic [2:0] ch);
    logic [N_IO-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_IO; i++) begin
      if (ch == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  tag_t              pipe [4];
  decode_t           rd_dec;
  decode_t           wr_dec;
  logic [2:0]        rd_lat;
  logic [2:0]        remaining;
  logic              accept;
  logic              fwd_hit;
  logic [1:0]        slot_idx;
  tag_t              new_tag;
  logic [DATA_W-1:0] io_sel_data;

  logic              wr_valid_q;
  logic [15:0]       wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign rd_dec = decode_addr(rd_addr);
  assign wr_dec = decode_addr(wr_addr_q);
  assign rd_lat = latency_of(rd_dec.region);

  // Cycles until the youngest pending read completes; accepting a new read
  // only when its latency exceeds this keeps completions ordered and distinct.
  always_comb begin
    remaining = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (pipe[k].valid) remaining = 3'(k);
    end
  end

  assign rd_ready = reset_n && (rd_lat > remaining);
  assign accept   = rd_req && rd_ready;
  assign slot_idx = 2'(rd_lat - 3'd1);

  // A RAM read that targets the word sitting in the write stage would see
  // stale RAM data, so the registered write data travels with the read.
  assign fwd_hit = wr_valid_q && (wr_dec.region == REG_RAM) &&
                   (rd_dec.region == REG_RAM) &&
                   (wr_addr_q[13:0] == rd_addr[13:0]);

  always_comb begin
    new_tag        = '0;
    new_tag.valid  = 1'b1;
    new_tag.region = rd_dec.region;
    new_tag.chan   = rd_dec.chan;
    new_tag.fwd    = fwd_hit;
    new_tag.fdata  = wr_data_q;
  end

  // Read address ports follow rd_addr combinationally while a request is up;
  // the IO strobe is reserved for the cycle the read is actually accepted.
  always_comb begin
    rom_addr   = '0;
    ram_rdaddr = '0;
    io_raddr   = '0;
    io_ren     = '0;
    if (rd_req) begin
      rom_addr   = rd_addr[14:0];
      ram_rdaddr = rd_addr[13:0];
      if (rd_dec.region == REG_IO) begin
        io_raddr = rd_addr - io_base_of(rd_dec.chan);
      end
    end
    if (accept && (rd_dec.region == REG_IO)) begin
      io_ren = onehot_of(rd_dec.chan);
    end
  end

  // Tag pipeline: shift toward completion every cycle and drop a newly
  // accepted read into the slot matching its latency.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) pipe[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) pipe[k] <= pipe[k + 1];
      pipe[3] <= '0;
      if (accept) pipe[slot_idx] <= new_tag;
    end
  end

  always_comb begin
    io_sel_data = '0;
    for (int i = 0; i < N_IO; i++) begin
      if (pipe[0].chan == 3'(i)) io_sel_data = io_rdata[i*DATA_W +: DATA_W];
    end
  end

  // Completion mux: data comes from whichever source the head tag names.
  always_comb begin
    rd_valid = pipe[0].valid;
    rd_data  = '0;
    rd_err   = 1'b0;
    if (pipe[0].valid) begin
      case (pipe[0].region)
        REG_ROM:  rd_data = rom_q;
        REG_RAM:  rd_data = pipe[0].fwd ? pipe[0].fdata : ram_q;
        REG_IO:   rd_data = io_sel_data;
        default:  rd_err  = 1'b1;
      endcase
    end
  end

  // Write stage: every write is registered once before it is issued.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= wr_req;
      wr_addr_q  <= wr_addr;
      wr_data_q  <= wr_data;
    end
  end

  // ROM-region writes fall through with no strobe at all.
  always_comb begin
    ram_wraddr = wr_addr_q[13:0];
    ram_wdata  = wr_data_q;
    ram_wren   = wr_valid_q && (wr_dec.region == REG_RAM);
    io_wdata   = wr_data_q;
    io_waddr   = '0;
    io_wen     = '0;
    if (wr_valid_q && (wr_dec.region == REG_IO)) begin
      io_waddr = wr_addr_q - io_base_of(wr_dec.chan);
      io_wen   = onehot_of(wr_dec.chan);
    end
  end

  // Sticky error: set by an unmapped read completing or an unmapped write
  // leaving the write stage; only reset clears it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus_error <= 1'b0;
    end else if ((rd_valid && rd_err) ||
                 (wr_valid_q && (wr_dec.region == REG_UNMAPPED))) begin
      bus_error <= 1'b1;
    end
  end

endmodule
